ifu_fetch: RTL and testbench



---
 rtl/ifu_fetch.sv | 118 +++++++++++
 tb/tb_ifu_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time,
// holds the returned word for decode and waits for execute to supply next_pc.
module ifu_fetch #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              pc_update_valid,
    input  logic [ADDR_W-1:0] next_pc,
    output logic              fetch_misaligned,
    output logic [31:0]       fetch_count
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_WAIT_PC,
        S_HALT
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_pc;
    logic [INST_W-1:0]   r_inst;
    logic [ADDR_W-1:0]   r_instPc;
    logic                r_misaligned;
    logic [31:0]         r_count;

    logic                w_capture;
    logic                w_pcLoad;
    logic                w_setMisaligned;
    logic                w_countInc;
    logic                w_pcAligned;

    assign w_pcAligned = (next_pc[1:0] == 2'b00);

    always_comb begin
        w_nextState     = r_state;
        w_capture       = 1'b0;
        w_pcLoad        = 1'b0;
        w_setMisaligned = 1'b0;
        w_countInc      = 1'b0;
        case (r_state)
            S_REQ: begin
                if (imem_req_ready) w_nextState = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_capture   = 1'b1;
                    w_nextState = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    w_countInc = 1'b1;
                    // Same-cycle next_pc skips WAIT_PC entirely.
                    if (pc_update_valid) begin
                        w_pcLoad        = w_pcAligned;
                        w_setMisaligned = !w_pcAligned;
                        w_nextState     = w_pcAligned ? S_REQ : S_HALT;
                    end else begin
                        w_nextState = S_WAIT_PC;
                    end
                end
            end
            S_WAIT_PC: begin
                if (pc_update_valid) begin
                    w_pcLoad        = w_pcAligned;
                    w_setMisaligned = !w_pcAligned;
                    w_nextState     = w_pcAligned ? S_REQ : S_HALT;
                end
            end
            S_HALT: w_nextState = S_HALT;
            default: w_nextState = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_instPc     <= RESET_PC;
            r_misaligned <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_capture) begin
                r_inst   <= imem_rsp_data;
                r_instPc <= r_pc;
            end
            if (w_pcLoad)        r_pc         <= next_pc;
            if (w_setMisaligned) r_misaligned <= 1'b1;
            if (w_countInc)      r_count      <= r_count + 32'd1;
        end
    end

    assign imem_req_valid   = (r_state == S_REQ);
    assign imem_req_addr    = r_pc;
    assign inst_valid       = (r_state == S_HOLD);
    assign inst             = r_inst;
    assign inst_pc          = r_instPc;
    assign fetch_misaligned = r_misaligned;
    assign fetch_count      = r_count;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch; the bench plays both the
// instruction memory and the execute stage.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        pc_update_valid;
    logic [31:0] next_pc;
    logic        fetch_misaligned;
    logic [31:0] fetch_count;

    int checks;
    int failures;

    ifu_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .pc_update_valid  (pc_update_valid),
        .next_pc          (next_pc),
        .fetch_misaligned (fetch_misaligned),
        .fetch_count      (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        inst_ready      = 1'b0;
        pc_update_valid = 1'b0;
        next_pc         = '0;
    endtask

    task automatic do_fetch(input logic [31:0] data);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_req_valid got %b exp 1", imem_req_valid);
        end
        checks++;
        if (imem_req_addr !== 32'h8000_0000) begin
            failures++;
            $display("[TB] FAIL reset_addr got %h exp 80000000", imem_req_addr);
        end
        checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h8000_0000) begin
            failures++;
            $display("[TB] FAIL reset_inst got v=%b inst=%h pc=%h exp v=0 inst=0 pc=80000000",
                     inst_valid, inst, inst_pc);
        end
        checks++;
        if (fetch_misaligned !== 1'b0 || fetch_count !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_status got mis=%b cnt=%0d exp mis=0 cnt=0",
                     fetch_misaligned, fetch_count);
        end
    endtask

    task automatic test_basic_fetch();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_wait got req=%b iv=%b exp req=0 iv=0",
                     imem_req_valid, inst_valid);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0413;
        step();
        imem_rsp_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 32'h8000_0000) begin
            failures++;
            $display("[TB] FAIL basic_hold got v=%b inst=%h pc=%h exp v=1 inst=00000413 pc=80000000",
                     inst_valid, inst, inst_pc);
        end
        inst_ready      = 1'b1;
        pc_update_valid = 1'b1;
        next_pc         = 32'h8000_0004;
        step();
        clear_inputs();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004 || fetch_count !== 32'd1) begin
            failures++;
            $display("[TB] FAIL basic_next got req=%b addr=%h cnt=%0d exp req=1 addr=80000004 cnt=1",
                     imem_req_valid, imem_req_addr, fetch_count);
        end
    endtask

    task automatic test_req_stall();
        // next_pc offered while in REQ must be ignored.
        pc_update_valid = 1'b1;
        next_pc         = 32'h8000_0400;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
                failures++;
                $display("[TB] FAIL req_stall[%0d] got req=%b addr=%h exp req=1 addr=80000004",
                         i, imem_req_valid, imem_req_addr);
            end
        end
        clear_inputs();
    endtask

    task automatic test_hold_stall();
        logic [3:0] pulses;
        pulses = 4'b1101;
        do_fetch(32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            imem_rsp_valid  = pulses[i];
            imem_rsp_data   = 32'h1111_0000 + 32'(i);
            pc_update_valid = 1'b1;
            next_pc         = 32'h8000_0800;
            step();
            checks++;
            if (inst_valid !== 1'b1 || inst !== 32'hDEAD_BEEF || inst_pc !== 32'h8000_0004) begin
                failures++;
                $display("[TB] FAIL hold_stall[%0d] got v=%b inst=%h pc=%h exp v=1 inst=deadbeef pc=80000004",
                         i, inst_valid, inst, inst_pc);
            end
        end
        clear_inputs();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        checks++;
        if (fetch_count !== 32'd2 || inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_release got cnt=%0d iv=%b req=%b exp cnt=2 iv=0 req=0",
                     fetch_count, inst_valid, imem_req_valid);
        end
    endtask

    task automatic test_wait_pc();
        // Stray inst_ready while nothing is held must not count.
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || fetch_count !== 32'd2) begin
                failures++;
                $display("[TB] FAIL wait_pc[%0d] got req=%b iv=%b cnt=%0d exp req=0 iv=0 cnt=2",
                         i, imem_req_valid, inst_valid, fetch_count);
            end
        end
        inst_ready      = 1'b0;
        pc_update_valid = 1'b1;
        next_pc         = 32'h8000_0100;
        step();
        clear_inputs();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
            failures++;
            $display("[TB] FAIL wait_pc_resume got req=%b addr=%h exp req=1 addr=80000100",
                     imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_misaligned();
        do_fetch(32'h0000_0013);
        checks++;
        if (inst_pc !== 32'h8000_0100) begin
            failures++;
            $display("[TB] FAIL mis_inst_pc got %h exp 80000100", inst_pc);
        end
        inst_ready      = 1'b1;
        pc_update_valid = 1'b1;
        next_pc         = 32'h8000_0102;
        step();
        clear_inputs();
        checks++;
        if (fetch_misaligned !== 1'b1 || imem_req_valid !== 1'b0 ||
            imem_req_addr !== 32'h8000_0100 || fetch_count !== 32'd3) begin
            failures++;
            $display("[TB] FAIL mis_halt got mis=%b req=%b addr=%h cnt=%0d exp mis=1 req=0 addr=80000100 cnt=3",
                     fetch_misaligned, imem_req_valid, imem_req_addr, fetch_count);
        end
        imem_req_ready  = 1'b1;
        inst_ready      = 1'b1;
        pc_update_valid = 1'b1;
        next_pc         = 32'h8000_0200;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_req_addr !== 32'h8000_0100) begin
                failures++;
                $display("[TB] FAIL halt_stuck[%0d] got req=%b iv=%b addr=%h exp req=0 iv=0 addr=80000100",
                         i, imem_req_valid, inst_valid, imem_req_addr);
            end
        end
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (fetch_misaligned !== 1'b0 || imem_req_valid !== 1'b1 ||
            imem_req_addr !== 32'h8000_0000 || fetch_count !== 32'd0) begin
            failures++;
            $display("[TB] FAIL halt_reset got mis=%b req=%b addr=%h cnt=%0d exp mis=0 req=1 addr=80000000 cnt=0",
                     fetch_misaligned, imem_req_valid, imem_req_addr, fetch_count);
        end
    endtask

    task automatic test_reset_mid_flight();
        do_fetch(32'h0000_0093);
        inst_ready      = 1'b1;
        pc_update_valid = 1'b1;
        next_pc         = 32'h8000_0010;
        step();
        clear_inputs();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 ||
            inst_valid !== 1'b0 || fetch_count !== 32'd0) begin
            failures++;
            $display("[TB] FAIL rst_wait got req=%b addr=%h iv=%b cnt=%0d exp req=1 addr=80000000 iv=0 cnt=0",
                     imem_req_valid, imem_req_addr, inst_valid, fetch_count);
        end
        do_fetch(32'h0000_00B3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h8000_0000 || imem_req_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_hold got iv=%b inst=%h pc=%h req=%b exp iv=0 inst=0 pc=80000000 req=1",
                     inst_valid, inst, inst_pc, imem_req_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expAddr;
        expAddr = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== expAddr) begin
                failures++;
                $display("[TB] FAIL b2b_addr[%0d] got req=%b addr=%h exp req=1 addr=%h",
                         i, imem_req_valid, imem_req_addr, expAddr);
            end
            do_fetch(32'h0000_1000 + 32'(i));
            checks++;
            if (inst !== 32'h0000_1000 + 32'(i) || inst_pc !== expAddr) begin
                failures++;
                $display("[TB] FAIL b2b_inst[%0d] got inst=%h pc=%h exp inst=%h pc=%h",
                         i, inst, inst_pc, 32'h0000_1000 + 32'(i), expAddr);
            end
            expAddr         = expAddr + 32'd4;
            inst_ready      = 1'b1;
            pc_update_valid = 1'b1;
            next_pc         = expAddr;
            step();
            clear_inputs();
        end
        checks++;
        if (fetch_count !== 32'd3 || imem_req_addr !== 32'h8000_000C) begin
            failures++;
            $display("[TB] FAIL b2b_final got cnt=%0d addr=%h exp cnt=3 addr=8000000c",
                     fetch_count, imem_req_addr);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clear_inputs();
        test_reset();
        test_basic_fetch();
        test_req_stall();
        test_hold_stall();
        test_wait_pc();
        test_misaligned();
        test_reset_mid_flight();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
